// File: rtl/memc_deskew.sv
// memc_deskew: captures one skewed DIMxDIM systolic result block and returns de-skewed rows.
// Readback latency 1 cycle; en low stalls capture. Define MEMC_ZERO_FILL_EN to clear the buffer on start.
module memc_deskew #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     en,
  input  logic signed [BITS_C-1:0] Cin [DIM],
  input  logic [$clog2(DIM)-1:0]   Crow,
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     busy,
  output logic                     done
);
  localparam int            CW       = $clog2(2*DIM);
  localparam logic [CW-1:0] CYC_LAST = CW'(2*DIM-2);

  typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cyc;
  logic                     cap_load;
  logic                     cap_adv;
  logic signed [BITS_C-1:0] mem [DIM][DIM];
  logic signed [BITS_C-1:0] row_sel [DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CAPTURE);
      done  <= (state_nxt == READY);
    end
  end

  // start is only honoured outside CAPTURE; a running block cannot be restarted
  always_comb begin
    state_nxt = state;
    cap_load  = 1'b0;
    cap_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CAPTURE;
          cap_load  = 1'b1;
        end
      end
      CAPTURE: begin
        if (en) begin
          cap_adv = 1'b1;
          if (cyc == CYC_LAST) state_nxt = READY;
        end
      end
      READY: begin
        if (start) begin
          state_nxt = CAPTURE;
          cap_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cyc <= '0;
    else if (cap_load) cyc <= '0;
    else if (cap_adv)  cyc <= cyc + 1'b1;
  end

  // lane i carries element k on enabled cycle k+i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++)
        for (int k = 0; k < DIM; k++)
          mem[i][k] <= '0;
    end else begin
`ifdef MEMC_ZERO_FILL_EN
      if (cap_load) begin
        for (int i = 0; i < DIM; i++)
          for (int k = 0; k < DIM; k++)
            mem[i][k] <= '0;
      end
`endif
      if (cap_adv) begin
        for (int i = 0; i < DIM; i++)
          for (int k = 0; k < DIM; k++)
            if (int'(cyc) == i + k) mem[i][k] <= Cin[i];
      end
    end
  end

  // rows beyond DIM-1 (non-power-of-two DIM) read as zero
  always_comb begin
    for (int j = 0; j < DIM; j++) row_sel[j] = '0;
    for (int r = 0; r < DIM; r++)
      if (int'(Crow) == r)
        for (int j = 0; j < DIM; j++) row_sel[j] = mem[r][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DIM; j++) Cout[j] <= '0;
    end else begin
      for (int j = 0; j < DIM; j++) Cout[j] <= row_sel[j];
    end
  end

endmodule
